tff_count_ctrl: RTL and testbench

Sequencing controller for a bank of T flip-flops, turning it into a start/stop-able modulo-MOD up/down counter with synchronous parallel load and one-shot mode. The block computes the per-bit toggle vector each cycle from its FSM state and the bank's current value; the bank stores the count. It sits between control logic issuing start/stop/load commands and any consumer of the count or terminal-count events, e.g. display drivers or timebase dividers.

---
 rtl/tff_count_ctrl_pkg.sv | 48 ++++
 rtl/tff_bank.sv | 33 +++
 rtl/tff_count_ctrl.sv | 104 ++++++++++
 tb/tb_tff_count_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and count helpers for the T-flip-flop counter controller.
// Helpers take the modulus as an argument so one package serves every WIDTH/MOD.
package tff_count_ctrl_pkg;

  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef logic [MAX_W-1:0] cnt_t;
  typedef logic [MAX_W:0]   mod_t;

  // True when advancing from q in the given direction wraps around.
  function automatic logic is_terminal(cnt_t q, logic up, mod_t modulus);
    logic res;
    if (up) begin
      res = ({1'b0, q} == (modulus - mod_t'(1)));
    end else begin
      res = (q == '0);
    end
    return res;
  endfunction

  function automatic cnt_t next_count(cnt_t q, logic up, mod_t modulus);
    cnt_t res;
    if (is_terminal(q, up, modulus)) begin
      res = up ? '0 : cnt_t'(modulus - mod_t'(1));
    end else begin
      res = up ? (q + cnt_t'(1)) : (q - cnt_t'(1));
    end
    return res;
  endfunction

  // Out-of-range load values saturate to the top of the count range.
  function automatic cnt_t clamp_load(cnt_t v, mod_t modulus);
    cnt_t res;
    if ({1'b0, v} >= modulus) begin
      res = cnt_t'(modulus - mod_t'(1));
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops with a synchronous parallel load that overrides toggling.
module tff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] t_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q ^ t_i;
    if (load_i) begin
      q_d = load_val_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Start/stop-able modulo-MOD up/down counter built on a T flip-flop bank.
// The controller only decides which bits toggle; the bank holds the count.
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam mod_t MOD_W = mod_t'(MOD);

  state_e           state_q;
  state_e           state_d;
  logic             adv;
  logic             term;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_q;
  logic             done_q;

  // An advance needs RUN at the start of the cycle and neither load nor stop.
  assign adv          = (state_q == ST_RUN) && !load && !stop;
  assign term         = adv && is_terminal(cnt_t'(q), up, MOD_W);
  assign nxt          = WIDTH'(next_count(cnt_t'(q), up, MOD_W));
  assign t_vec        = adv ? (q ^ nxt) : '0;
  assign load_clamped = WIDTH'(clamp_load(cnt_t'(load_val), MOD_W));

  tff_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (load_clamped),
    .t_i        (t_vec),
    .q_o        (q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command priority: load, then stop, then start; oneshot terminal last.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (term && oneshot) begin
            state_d = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= term;
      done_q <= term && oneshot;
    end
  end

  always_comb begin
    busy      = (state_q == ST_RUN);
    wrap      = wrap_q;
    done      = done_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: directed scenarios plus random commands, all checked
// against an arithmetic model of the counter kept alongside the DUT.
module tb_tff_count_ctrl;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             up = 1'b1;
  logic             oneshot = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             wrap;
  logic             done;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Model: count value, state (0 idle, 1 run, 2 pause) and pulse outputs.
  int m_cnt   = 0;
  int m_state = 0;
  bit m_wrap  = 1'b0;
  bit m_done  = 1'b0;
  int wrap_seen;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  tff_count_ctrl #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .up        (up),
    .oneshot   (oneshot),
    .load      (load),
    .load_val  (load_val),
    .q         (q),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("q", 32'(q), 32'(m_cnt));
    check("busy", 32'(busy), 32'(m_state == 1));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("done", 32'(done), 32'(m_done));
    check("state", 32'(state_dbg), 32'(m_state));
  endtask

  // ---------------- reference model ----------------
  task automatic model_edge();
    bit adv;
    bit term;
    adv  = (m_state == 1) && !load && !stop;
    term = adv && (up ? (m_cnt == MOD - 1) : (m_cnt == 0));
    m_wrap = term;
    m_done = term && oneshot;
    if (load) begin
      m_cnt   = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
      m_state = 0;
    end else begin
      if (adv) m_cnt = up ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
      if (stop && m_state == 1)        m_state = 2;
      else if (start && m_state != 1)  m_state = 1;
      else if (term && oneshot)        m_state = 0;
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_state = 0;
    m_wrap  = 1'b0;
    m_done  = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (wrap === 1'b1) wrap_seen++;
  endtask

  task automatic clear_cmds();
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
  endtask

  task automatic do_load(input int v);
    load_val = WIDTH'(v);
    load     = 1'b1;
    cycle();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Drop reset between edges, check the asynchronous clear, then release.
  task automatic async_reset();
    @(posedge clk);
    model_edge();
    #4;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst_q", 32'(q), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check_all();
    #2;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b1;

    // Free run up from reset: 0..9, 0, 1 with one wrap pulse.
    up = 1'b1;
    oneshot = 1'b0;
    do_start();
    check("first_after_start", 32'(q), 32'd0);
    wrap_seen = 0;
    repeat (11) cycle();
    check("run12_q", 32'(q), 32'd1);
    check("run12_wraps", 32'(wrap_seen), 32'd1);

    // Oneshot down from 3: 3, 2, 1, 0, 9 then idle.
    up = 1'b0;
    oneshot = 1'b1;
    do_load(3);
    do_start();
    repeat (4) cycle();
    check("oneshot_q", 32'(q), 32'd9);
    check("oneshot_done", 32'(done), 32'd1);
    check("oneshot_wrap", 32'(wrap), 32'd1);
    check("oneshot_busy", 32'(busy), 32'd0);
    repeat (2) cycle();
    check("oneshot_hold", 32'(q), 32'd9);
    oneshot = 1'b0;

    // Pause at 5 and resume.
    up = 1'b1;
    do_load(5);
    do_start();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (4) cycle();
    check("pause_hold", 32'(q), 32'd5);
    do_start();
    check("resume_first_edge", 32'(q), 32'd5);
    cycle();
    check("resume_q", 32'(q), 32'd6);

    // Load, stop and start together at 7: load wins, value clamped.
    do_load(7);
    do_start();
    load = 1'b1;
    stop = 1'b1;
    start = 1'b1;
    load_val = 4'd15;
    cycle();
    clear_cmds();
    check("clamp_q", 32'(q), 32'd9);
    check("clamp_state", 32'(state_dbg), 32'd0);

    // Asynchronous reset at 6; count stays at 0 until a new start.
    do_load(2);
    do_start();
    repeat (3) cycle();
    check("pre_rst_q", 32'(q), 32'd5);
    async_reset();
    repeat (3) cycle();
    check("post_rst_q", 32'(q), 32'd0);

    // Direction flip mid-run: 4, 5, 4, 3 without a wrap.
    do_load(4);
    do_start();
    wrap_seen = 0;
    cycle();
    up = 1'b0;
    cycle();
    cycle();
    check("flip_q", 32'(q), 32'd3);
    check("flip_nowrap", 32'(wrap_seen), 32'd0);

    // Random commands.
    for (int i = 0; i < 3000; i++) begin
      load     = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 14) == 0);
      start    = ($urandom_range(0, 5) == 0);
      load_val = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) up = ~up;
      if ($urandom_range(0, 29) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 399) == 0) begin
        clear_cmds();
        async_reset();
      end else begin
        cycle();
      end
    end
    clear_cmds();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
